// File: rtl/shift_sequencer_if.sv
// Handshake and operand/result bundle between the execute stage and the shift sequencer.
interface shift_sequencer_if #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned SHW   = 6
);
    logic             start;
    logic             flush;
    logic [1:0]       op;
    logic [WIDTH-1:0] data_in;
    logic [SHW-1:0]   shamt;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;

    modport master (
        output start, flush, op, data_in, shamt,
        input  busy, done, result
    );

    modport slave (
        input  start, flush, op, data_in, shamt,
        output busy, done, result
    );
endinterface

// File: rtl/shift_sequencer.sv
// Multi-cycle LSL/LSR/ASR/ROR sequencer: one power-of-two stage per clock,
// stopping after the highest set bit of the shift amount.
module shift_sequencer #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned SHW   = 6
) (
    input  logic                clk,
    input  logic                reset_n,
    shift_sequencer_if.slave    bus
);
    localparam int unsigned CW = $clog2(SHW);
    localparam int unsigned KW = SHW + 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [1:0] OP_LSL = 2'b00;
    localparam logic [1:0] OP_LSR = 2'b01;
    localparam logic [1:0] OP_ASR = 2'b10;

    logic [1:0]       state_q,  state_d;
    logic [WIDTH-1:0] acc_q,    acc_d;
    logic [1:0]       op_q,     op_d;
    logic [SHW-1:0]   sh_q,     sh_d;
    logic [CW-1:0]    cnt_q,    cnt_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             busy_q,   busy_d;
    logic             done_q,   done_d;

    logic [WIDTH-1:0] acc_next;
    logic [KW-1:0]    stage_k;
    logic             upper_zero;

    // One fixed-distance stage; ASR keeps the accumulator MSB, which never changes after accept.
    function automatic logic [WIDTH-1:0] stage(input logic [WIDTH-1:0] a,
                                               input logic [1:0]       op,
                                               input logic [KW-1:0]    k);
        logic [WIDTH-1:0] r;
        case (op)
            OP_LSL:  r = a << k;
            OP_LSR:  r = a >> k;
            OP_ASR:  r = $unsigned($signed(a) >>> k);
            default: r = (a >> k) | (a << (KW'(WIDTH) - k));
        endcase
        return r;
    endfunction

    assign stage_k    = KW'(1) << cnt_q;
    assign upper_zero = ((sh_q >> cnt_q) >> 1) == '0;

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        op_d     = op_q;
        sh_d     = sh_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        acc_next = acc_q;

        if (bus.flush) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    state_d = IDLE;
                    if (bus.start) begin
                        acc_d = bus.data_in;
                        op_d  = bus.op;
                        sh_d  = bus.shamt;
                        cnt_d = '0;
                        if (bus.shamt == '0) begin
                            state_d  = DONE;
                            result_d = bus.data_in;
                        end else begin
                            state_d  = RUN;
                        end
                    end
                end
                RUN: begin
                    if (sh_q[cnt_q]) begin
                        acc_next = stage(acc_q, op_q, stage_k);
                    end
                    acc_d = acc_next;
                    if (upper_zero) begin
                        result_d = acc_next;
                        state_d  = DONE;
                    end else begin
                        cnt_d    = cnt_q + CW'(1);
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        busy_d = (state_d == RUN);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            acc_q    <= '0;
            op_q     <= '0;
            sh_q     <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            op_q     <= op_d;
            sh_q     <= sh_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.result = result_q;
endmodule

// File: tb/tb_shift_sequencer.sv
// Directed bench for shift_sequencer: the driver queues expected results,
// an independent monitor pops and compares them on every done pulse.
module tb_shift_sequencer;
    localparam int unsigned WIDTH = 64;
    localparam int unsigned SHW   = 6;

    localparam logic [1:0] LSL = 2'b00;
    localparam logic [1:0] LSR = 2'b01;
    localparam logic [1:0] ASR = 2'b10;
    localparam logic [1:0] ROR = 2'b11;

    typedef struct {
        logic [63:0] res;
        int          cyc;
    } exp_t;

    logic clk     = 1'b0;
    logic reset_n = 1'b1;
    int   cyc     = 0;
    int   n_vec   = 0;
    int   n_err   = 0;
    int   done_seen = 0;
    exp_t exp_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    shift_sequencer_if #(.WIDTH(WIDTH), .SHW(SHW)) bus ();

    shift_sequencer #(.WIDTH(WIDTH), .SHW(SHW)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Scoreboard monitor: each done pulse must match the oldest queued expectation.
    exp_t mon_e;
    always @(negedge clk) begin
        if (reset_n && bus.done === 1'b1) begin
            done_seen++;
            chk("busy_and_done", 64'(bus.busy), 64'd0);
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_done: got done with result %0h, expected no pending op", bus.result);
            end else begin
                mon_e = exp_q.pop_front();
                chk("result", bus.result, mon_e.res);
                chk("done_cycle", 64'(cyc), 64'(mon_e.cyc));
            end
        end
    end

    // Issue one op at a negedge; returns at the negedge where done is seen.
    task automatic issue(input logic [1:0] op, input logic [63:0] d, input logic [5:0] sh,
                         input logic [63:0] res, input int lat, input bit glitch);
        exp_t e;
        int   busy_n = 0;
        bit   got    = 1'b0;
        e.res = res;
        e.cyc = cyc + 1 + lat;
        exp_q.push_back(e);
        bus.start   = 1'b1;
        bus.op      = op;
        bus.data_in = d;
        bus.shamt   = sh;
        @(negedge clk);
        bus.start   = 1'b0;
        bus.data_in = ~d;
        bus.shamt   = ~sh;
        for (int i = 0; i < 20 && !got; i++) begin
            if (bus.done === 1'b1) begin
                got = 1'b1;
            end else begin
                if (bus.busy === 1'b1) busy_n++;
                if (glitch && i == 1) begin
                    bus.start   = 1'b1;
                    bus.op      = ROR;
                    bus.data_in = 64'hA5A5_A5A5_A5A5_A5A5;
                    bus.shamt   = 6'd7;
                end else begin
                    bus.start   = 1'b0;
                end
                @(negedge clk);
            end
        end
        bus.start = 1'b0;
        if (!got) begin
            n_vec++;
            n_err++;
            $display("FAIL done_timeout: got no done in 20 cycles, expected done after %0d", lat);
        end
        chk("busy_cycles", 64'(busy_n), 64'(lat));
    endtask

    initial begin
        int ds;
        bus.start   = 1'b0;
        bus.flush   = 1'b0;
        bus.op      = LSL;
        bus.data_in = '0;
        bus.shamt   = '0;
        #1 reset_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_busy",   64'(bus.busy), 64'd0);
        chk("reset_done",   64'(bus.done), 64'd0);
        chk("reset_result", bus.result,    64'd0);
        reset_n = 1'b1;
        @(negedge clk);

        issue(LSL, 64'h1, 6'd3, 64'h8, 2, 1'b0);
        issue(ASR, 64'h8000_0000_0000_0000, 6'd63, 64'hFFFF_FFFF_FFFF_FFFF, 6, 1'b0);
        issue(LSR, 64'hF0, 6'd4, 64'hF, 3, 1'b0);
        issue(ROR, 64'h1, 6'd1, 64'h8000_0000_0000_0000, 1, 1'b0);
        issue(ROR, 64'h0123_4567_89AB_CDEF, 6'd32, 64'h89AB_CDEF_0123_4567, 6, 1'b0);
        issue(LSL, 64'hDEAD, 6'd0, 64'hDEAD, 0, 1'b0);
        issue(LSL, 64'hDEAD, 6'd4, 64'hD_EAD0, 3, 1'b0);
        issue(LSR, 64'h8000_0000_0000_0000, 6'd63, 64'h1, 6, 1'b0);
        issue(ASR, 64'h8000_0000_0000_0000, 6'd4, 64'hF800_0000_0000_0000, 3, 1'b0);
        issue(ROR, 64'h1, 6'd63, 64'h2, 6, 1'b0);
        issue(LSL, 64'hFFFF_FFFF_FFFF_FFFF, 6'd5, 64'hFFFF_FFFF_FFFF_FFE0, 3, 1'b0);
        issue(LSL, 64'h1, 6'd40, 64'h0000_0100_0000_0000, 6, 1'b1);
        @(negedge clk);

        // Flush at the third RUN cycle: no done, result keeps its old value.
        ds = done_seen;
        bus.start   = 1'b1;
        bus.op      = ASR;
        bus.data_in = 64'hFF00;
        bus.shamt   = 6'd63;
        @(negedge clk);
        bus.start   = 1'b0;
        repeat (2) @(negedge clk);
        bus.flush = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0;
        chk("flush_busy", 64'(bus.busy), 64'd0);
        chk("flush_done", 64'(bus.done), 64'd0);
        repeat (8) @(negedge clk);
        chk("flush_result", bus.result, 64'h0000_0100_0000_0000);
        chk("flush_no_done", 64'(done_seen - ds), 64'd0);

        // Start coinciding with flush is dropped.
        bus.flush   = 1'b1;
        bus.start   = 1'b1;
        bus.op      = LSL;
        bus.data_in = 64'h3;
        bus.shamt   = 6'd5;
        @(negedge clk);
        bus.flush = 1'b0;
        bus.start = 1'b0;
        chk("flush_start_busy", 64'(bus.busy), 64'd0);
        repeat (8) @(negedge clk);
        chk("flush_start_result", bus.result, 64'h0000_0100_0000_0000);

        // Asynchronous reset between edges in the middle of RUN.
        bus.start   = 1'b1;
        bus.op      = ROR;
        bus.data_in = 64'h0123_4567_89AB_CDEF;
        bus.shamt   = 6'd63;
        @(negedge clk);
        bus.start = 1'b0;
        @(posedge clk);
        #3 reset_n = 1'b0;
        #1;
        chk("async_rst_busy",   64'(bus.busy), 64'd0);
        chk("async_rst_done",   64'(bus.done), 64'd0);
        chk("async_rst_result", bus.result,    64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        issue(LSR, 64'hF0, 6'd4, 64'hF, 3, 1'b0);
        repeat (3) @(negedge clk);
        chk("queue_drained", 64'(exp_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test, expected completion before 200000");
        $fatal(1, "watchdog expired");
    end
endmodule
